alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issuing end of the ALU interface in the 8-bit computer. Accepts byte-wide instructions over a valid/ready handshake and holds a four-entry register file (A, B, C, D). Drives `enable`/`mode`/`in_a`/`in_b` of the registered ALU, writes the result back, and keeps shadow copies of the zero and carry flags for test instructions. One instruction is in flight at a time; no hazards exist by construction.

## Interface
- `N`, default 8: data width, N ≥ 8. Opcode fields always occupy `instr[7:0]`; upper bits are ignored for opcode bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction or immediate byte offered.
- `instr` in N: instruction `{op[7:4], dst[3:2], src[1:0]}`, or immediate data.
- `instr_ready` out 1: sequencer accepts `instr` this cycle.
- `alu_enable` out 1: ALU enable, one-cycle pulse.
- `alu_mode` out 3: ALU operation code.
- `alu_a` out N: ALU operand A = R[dst].
- `alu_b` out N: ALU operand B = R[src].
- `alu_out` in N: ALU registered result.
- `alu_zero` in 1: ALU zero flag.
- `alu_carry` in 1: ALU carry flag.
- `flag_zero` out 1: shadow zero flag.
- `flag_carry` out 1: shadow carry flag.
- `cond_valid` out 1: one-cycle pulse carrying a test result.
- `cond` out 1: test result, qualified by `cond_valid`.
- `err` out 1: one-cycle pulse on an illegal opcode.
- `reg_sel` in 2: debug read select.
- `reg_data` out N: combinational R[reg_sel].

## Operation
- Opcodes:
  - 0–7: ALU ops ADD, ADC, SUB, INC, DEC, AND, OR, XOR; `alu_mode = op[2:0]`; R[dst] ← `alu_out`.
  - 8 MOV: R[dst] ← R[src]; no ALU use; flags unchanged.
  - 9 LDI: second handshake byte → R[dst].
  - A CMP: SUB without writeback; flags updated.
  - B TSTZ: `cond = flag_zero`.
  - C TSTC: `cond = flag_carry`.
  - D–F: illegal; `err` pulses; no state change.
- States: IDLE, IMM, EXEC, WB.
  - IDLE: `instr_ready = 1`. On handshake: ops 0–7 and A → EXEC; 9 → IMM; 8, B, C, D–F complete in the handshake cycle and stay in IDLE.
  - IMM: `instr_ready = 1`. Waits indefinitely; on handshake R[dst] ← `instr`, → IDLE.
  - EXEC: `alu_enable = 1`; mode and operands stable → WB.
  - WB: latch `alu_zero` and `alu_carry` into the shadow flags; write R[dst] unless CMP → IDLE.
- Flags:
  - Logic ops (AND/OR/XOR) copy `alu_carry` as-is; the ALU leaves carry untouched for those ops.
  - INC/DEC/ADD/SUB carry follows ALU N+1-bit wrap semantics, e.g. 0xFF+1 → 0x00, carry 1.
- Outside EXEC: `alu_enable = 0`, `alu_mode = 0`, operands held at the last values.
- `instr_ready = 0` in EXEC and WB. Valid may be held there; nothing is consumed.

## Timing
- Reset values:
  - state IDLE; R[0..3] = 0.
  - `flag_zero = flag_carry = 0`.
  - `alu_enable`, `cond_valid`, `cond`, `err` = 0.
  - `instr_ready = 1` from the first cycle after reset deasserts.
- Reset overrides everything, including mid-EXEC/WB (no writeback) and mid-IMM (immediate dropped). The ALU's internal flags are not reset; the shadow flags are authoritative.
- ALU op: handshake at cycle t, `alu_enable` high at t+1, writeback and flags at the end of t+2, `instr_ready` high at t+3. Throughput is 1 ALU op per 3 cycles.
- MOV/TSTZ/TSTC/illegal: effect or pulse in the cycle after the handshake; next instruction accepted in that same cycle.
- TSTZ/TSTC immediately following an ALU op see the WB-updated flags.
- `reg_data` reflects a write from the following cycle.

## Structure
- Shared package `alu_pkg` (also used by `alu`) holds:
  - ALU mode constants `ALU_ADD`=0 … `ALU_XOR`=7.
  - Opcode constants `OP_MOV`=8, `OP_LDI`=9, `OP_CMP`=A, `OP_TSTZ`=B, `OP_TSTC`=C.
  - State encoding.
- Natural sub-module: `regfile4`, 4×N, one synchronous write port, two combinational read ports plus the debug read port.

## Test plan
- Reset, then LDI A=0x05, LDI B=0x03, ADD A,B → R[A]=0x08, zero 0, carry 0; `alu_enable` high exactly one cycle, at handshake+1.
- LDI A=0xFF, INC A → R[A]=0x00, zero 1, carry 1; TSTZ → `cond_valid` with `cond` 1; TSTC → `cond` 1.
- LDI A=0x10, LDI B=0x10, CMP A,B → R[A] still 0x10, zero 1; MOV C,A → `reg_data[C]` = 0x10, flags unchanged.
- ADC after SUB 0x00-0x01 (carry 1): A=0x01, B=0x01 → R[A]=0x03.
- Opcode 0xE0 → `err` pulse one cycle, registers and flags unchanged; `instr_valid` held during EXEC → no acceptance until `instr_ready`.
- Reset asserted during EXEC of ADD → no writeback, R all 0, flags 0, IDLE next cycle; reset during IMM → following byte decoded as an opcode.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: ALU mode codes,
// sequencer opcodes, FSM state encoding and the instruction byte layout.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_ADC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_INC = 3'd3;
  localparam logic [2:0] ALU_DEC = 3'd4;
  localparam logic [2:0] ALU_AND = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_TSTZ = 4'hB;
  localparam logic [3:0] OP_TSTC = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IMM,
    ST_EXEC,
    ST_WB
  } seq_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src;
  } instr_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus the ALU drive/result bus of the sequencer.
interface alu_sequencer_if #(parameter int N = 8);
  logic         instr_valid;
  logic [N-1:0] instr;
  logic         instr_ready;
  logic         alu_enable;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_out;
  logic         alu_zero;
  logic         alu_carry;

  modport master (
    output instr_valid, instr, alu_out, alu_zero, alu_carry,
    input  instr_ready, alu_enable, alu_mode, alu_a, alu_b
  );

  modport slave (
    input  instr_valid, instr, alu_out, alu_zero, alu_carry,
    output instr_ready, alu_enable, alu_mode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_sequencer_regfile4.sv
// Four-entry register file: one synchronous write port, two combinational
// read ports and a combinational debug read port.
module regfile4 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [1:0]   ra_sel,
  output logic [N-1:0] ra_data,
  input  logic [1:0]   rb_sel,
  output logic [N-1:0] rb_data,
  input  logic [1:0]   dbg_sel,
  output logic [N-1:0] dbg_data
);

  logic [3:0][N-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)   regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Issues byte instructions to a registered ALU, one in flight at a time,
// and owns the register file plus shadow zero/carry flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_sequencer_if.slave bus,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         cond_valid,
  output logic         cond,
  output logic         err,
  input  logic [1:0]   reg_sel,
  output logic [N-1:0] reg_data
);

  seq_state_e   state;
  instr_t       dec;
  logic         take;
  logic [3:0]   cur_op;
  logic [1:0]   cur_dst;
  logic         we;
  logic [1:0]   waddr;
  logic [N-1:0] wdata;
  logic [N-1:0] rd_dst;
  logic [N-1:0] rd_src;

  assign dec             = instr_t'(bus.instr[7:0]);
  assign bus.instr_ready = (state == ST_IDLE) || (state == ST_IMM);
  assign take            = bus.instr_valid && bus.instr_ready;

  // Read ports follow the incoming byte so MOV and operand capture see R[dst]/R[src].
  regfile4 #(.N(N)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ra_sel   (dec.dst),
    .ra_data  (rd_dst),
    .rb_sel   (dec.src),
    .rb_data  (rd_src),
    .dbg_sel  (reg_sel),
    .dbg_data (reg_data)
  );

  always_comb begin
    we    = 1'b0;
    waddr = dec.dst;
    wdata = rd_src;
    case (state)
      ST_IDLE: if (take && dec.op == OP_MOV) we = 1'b1;
      ST_IMM: if (bus.instr_valid) begin
        we    = 1'b1;
        waddr = cur_dst;
        wdata = bus.instr;
      end
      ST_WB: if (cur_op != OP_CMP) begin
        we    = 1'b1;
        waddr = cur_dst;
        wdata = bus.alu_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cur_op         <= '0;
      cur_dst        <= '0;
      bus.alu_enable <= 1'b0;
      bus.alu_mode   <= ALU_ADD;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      flag_zero      <= 1'b0;
      flag_carry     <= 1'b0;
      cond_valid     <= 1'b0;
      cond           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.alu_enable <= 1'b0;
      bus.alu_mode   <= ALU_ADD;
      cond_valid     <= 1'b0;
      err            <= 1'b0;
      case (state)
        ST_IDLE: if (take) begin
          cur_op  <= dec.op;
          cur_dst <= dec.dst;
          if (!dec.op[3] || dec.op == OP_CMP) begin
            state          <= ST_EXEC;
            bus.alu_enable <= 1'b1;
            bus.alu_mode   <= (dec.op == OP_CMP) ? ALU_SUB : dec.op[2:0];
            bus.alu_a      <= rd_dst;
            bus.alu_b      <= rd_src;
          end else begin
            case (dec.op)
              OP_MOV: ;
              OP_LDI: state <= ST_IMM;
              OP_TSTZ: begin
                cond_valid <= 1'b1;
                cond       <= flag_zero;
              end
              OP_TSTC: begin
                cond_valid <= 1'b1;
                cond       <= flag_carry;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_IMM:  if (bus.instr_valid) state <= ST_IDLE;
        ST_EXEC: state <= ST_WB;
        ST_WB: begin
          flag_zero  <= bus.alu_zero;
          flag_carry <= bus.alu_carry;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: registered ALU device, behavioural cycle model,
// per-cycle compare process, directed literal checks and a random phase.
module tb_alu_sequencer;
  localparam int N = 8;

  logic clk;
  logic rst;
  logic flag_zero, flag_carry, cond_valid, cond, err;
  logic [1:0]   reg_sel;
  logic [N-1:0] reg_data;

  alu_sequencer_if #(.N(N)) bus ();

  alu_sequencer #(.N(N)) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .cond_valid (cond_valid),
    .cond       (cond),
    .err        (err),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ALU device; its carry is never reset.
  logic [N:0] dev_w;
  logic       dev_logic;
  logic       dev_c = 1'b0;

  always_comb begin
    dev_w     = '0;
    dev_logic = 1'b0;
    case (bus.alu_mode)
      3'd0: dev_w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: dev_w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, dev_c};
      3'd2: dev_w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd3: dev_w = {1'b0, bus.alu_a} + (N+1)'(1);
      3'd4: dev_w = {1'b0, bus.alu_a} - (N+1)'(1);
      3'd5: begin dev_w = {1'b0, bus.alu_a & bus.alu_b}; dev_logic = 1'b1; end
      3'd6: begin dev_w = {1'b0, bus.alu_a | bus.alu_b}; dev_logic = 1'b1; end
      default: begin dev_w = {1'b0, bus.alu_a ^ bus.alu_b}; dev_logic = 1'b1; end
    endcase
  end

  always @(posedge clk) begin
    if (bus.alu_enable) begin
      bus.alu_out  <= dev_w[N-1:0];
      bus.alu_zero <= (dev_w[N-1:0] == '0);
      if (!dev_logic) dev_c <= dev_w[N];
    end
  end
  assign bus.alu_carry = dev_c;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what each output must be in the current cycle.
  logic [N-1:0] m_R [4];
  logic         m_fz = 1'b0, m_fc = 1'b0, m_ac = 1'b0;
  logic         m_ready = 1'b1, m_en = 1'b0, m_cv = 1'b0, m_cond = 1'b0, m_err = 1'b0;
  logic [2:0]   m_mode = 3'd0;
  logic [N-1:0] m_a = '0, m_b = '0;
  int           m_busy = 0;
  logic         m_imm = 1'b0, m_took = 1'b0, chk_en = 1'b0;
  logic [1:0]   imm_dst = '0, p_dst = '0, md, ms;
  logic [3:0]   p_op = '0, mop;
  logic [N-1:0] st_res = '0;
  logic         st_z = 1'b0, st_c = 1'b0;

  task automatic model_alu();
    int  x, y, s;
    logic lg;
    x  = int'(m_a);
    y  = int'(m_b);
    lg = 1'b0;
    case (m_mode)
      3'd0: s = x + y;
      3'd1: s = x + y + int'(m_ac);
      3'd2: s = x - y;
      3'd3: s = x + 1;
      3'd4: s = x - 1;
      3'd5: begin s = x & y; lg = 1'b1; end
      3'd6: begin s = x | y; lg = 1'b1; end
      default: begin s = x ^ y; lg = 1'b1; end
    endcase
    st_res = s[N-1:0];
    st_z   = (st_res == '0);
    if (!lg) m_ac = s[N];
    st_c = m_ac;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_R[i] = '0;
    forever begin
      @(posedge clk);
      m_took = 1'b0;
      if (m_en) model_alu();
      m_en = 1'b0; m_mode = 3'd0; m_cv = 1'b0; m_err = 1'b0;
      if (rst) begin
        for (int i = 0; i < 4; i++) m_R[i] = '0;
        m_fz = 1'b0; m_fc = 1'b0; m_busy = 0; m_imm = 1'b0; m_cond = 1'b0;
        chk_en = 1'b1;
      end else if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_fz = st_z; m_fc = st_c;
        if (p_op != 4'hA) m_R[p_dst] = st_res;
        m_busy = 0;
      end else if (bus.instr_valid) begin
        m_took = 1'b1;
        if (m_imm) begin
          m_R[imm_dst] = bus.instr;
          m_imm = 1'b0;
        end else begin
          mop = bus.instr[7:4]; md = bus.instr[3:2]; ms = bus.instr[1:0];
          if (mop < 4'h8 || mop == 4'hA) begin
            m_en = 1'b1; m_mode = (mop == 4'hA) ? 3'd2 : mop[2:0];
            m_a = m_R[md]; m_b = m_R[ms]; m_busy = 2; p_op = mop; p_dst = md;
          end else if (mop == 4'h8) m_R[md] = m_R[ms];
          else if (mop == 4'h9) begin m_imm = 1'b1; imm_dst = md; end
          else if (mop == 4'hB) begin m_cv = 1'b1; m_cond = m_fz; end
          else if (mop == 4'hC) begin m_cv = 1'b1; m_cond = m_fc; end
          else m_err = 1'b1;
        end
      end
      m_ready = (m_busy == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(m_ready));
      chk("alu_enable", 32'(bus.alu_enable), 32'(m_en));
      chk("alu_mode", 32'(bus.alu_mode), 32'(m_mode));
      if (m_en) begin
        chk("alu_a", 32'(bus.alu_a), 32'(m_a));
        chk("alu_b", 32'(bus.alu_b), 32'(m_b));
      end
      chk("cond_valid", 32'(cond_valid), 32'(m_cv));
      if (m_cv) chk("cond", 32'(cond), 32'(m_cond));
      chk("err", 32'(err), 32'(m_err));
      chk("flag_zero", 32'(flag_zero), 32'(m_fz));
      chk("flag_carry", 32'(flag_carry), 32'(m_fc));
      chk("reg_data", 32'(reg_data), 32'(m_R[reg_sel]));
    end
  end

  int last_wait;

  task automatic step();
    @(posedge clk);
    #1;
    reg_sel = 2'($urandom);
  endtask

  task automatic issue(input logic [N-1:0] b);
    bus.instr_valid = 1'b1;
    bus.instr       = b;
    last_wait       = 0;
    do begin
      step();
      last_wait++;
    end while (!m_took && last_wait < 20);
    if (!m_took) chk("issue_timeout", 32'(0), 32'(1));
    bus.instr_valid = 1'b0;
  endtask

  task automatic ldi(input logic [1:0] d, input logic [N-1:0] val);
    issue({4'h9, d, 2'b00});
    issue(val);
  endtask

  task automatic rd(input string name, input logic [1:0] idx, input logic [N-1:0] exp);
    reg_sel = idx;
    #1;
    chk(name, 32'(reg_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    reg_sel = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.instr_ready), 32'(1));
    chk("rst_enable", 32'(bus.alu_enable), 32'(0));
    chk("rst_flags", 32'({flag_zero, flag_carry}), 32'(0));
    for (int i = 0; i < 4; i++) rd("rst_reg", 2'(i), '0);

    // ADD A,B with 5 and 3
    ldi(2'd0, 8'h05); ldi(2'd1, 8'h03);
    issue(8'h01);
    chk("add_en_t1", 32'(bus.alu_enable), 32'(1));
    chk("add_a", 32'(bus.alu_a), 32'h05);
    chk("add_b", 32'(bus.alu_b), 32'h03);
    step();
    chk("add_en_t2", 32'(bus.alu_enable), 32'(0));
    chk("add_ready_t2", 32'(bus.instr_ready), 32'(0));
    step();
    chk("add_ready_t3", 32'(bus.instr_ready), 32'(1));
    rd("add_res", 2'd0, 8'h08);
    chk("model_add", 32'(m_R[0]), 32'h08);
    chk("add_flags", 32'({flag_zero, flag_carry}), 32'(0));

    // INC 0xFF wraps with carry, then tests
    ldi(2'd0, 8'hFF);
    issue(8'h30); step(); step();
    rd("inc_res", 2'd0, 8'h00);
    chk("inc_flags", 32'({flag_zero, flag_carry}), 32'b11);
    issue(8'hB0);
    chk("tstz_cv", 32'(cond_valid), 32'(1));
    chk("tstz_cond", 32'(cond), 32'(1));
    issue(8'hC0);
    chk("tstc_cond", 32'(cond), 32'(1));

    // CMP leaves R[A], then MOV C,A
    ldi(2'd0, 8'h10); ldi(2'd1, 8'h10);
    issue(8'hA1); step(); step();
    rd("cmp_keep", 2'd0, 8'h10);
    chk("cmp_flags", 32'({flag_zero, flag_carry}), 32'b10);
    issue(8'h88);
    rd("mov_res", 2'd2, 8'h10);
    chk("mov_flags", 32'({flag_zero, flag_carry}), 32'b10);

    // SUB borrow feeds ADC
    ldi(2'd0, 8'h00); ldi(2'd1, 8'h01);
    issue(8'h21); step(); step();
    rd("sub_res", 2'd0, 8'hFF);
    chk("sub_carry", 32'(flag_carry), 32'(1));
    ldi(2'd0, 8'h01); ldi(2'd1, 8'h01);
    issue(8'h11); step(); step();
    rd("adc_res", 2'd0, 8'h03);
    chk("model_adc", 32'(m_R[0]), 32'h03);

    // Illegal opcode
    issue(8'hE0);
    chk("err_pulse", 32'(err), 32'(1));
    step();
    chk("err_clear", 32'(err), 32'(0));
    rd("err_keep", 2'd0, 8'h03);
    chk("err_flags", 32'({flag_zero, flag_carry}), 32'(0));

    // Valid held through EXEC/WB
    issue(8'h01);
    issue(8'hB0);
    chk("held_wait", 32'(last_wait), 32'(3));
    chk("held_cond", 32'(cond), 32'(0));

    // Reset during EXEC
    issue(8'h01);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rexec_ready", 32'(bus.instr_ready), 32'(1));
    for (int i = 0; i < 4; i++) rd("rexec_reg", 2'(i), '0);
    chk("rexec_flags", 32'({flag_zero, flag_carry}), 32'(0));

    // Reset during IMM: next byte is an opcode
    issue(8'h9C);
    rst = 1'b1; step(); rst = 1'b0;
    issue(8'hB0);
    chk("rimm_cv", 32'(cond_valid), 32'(1));
    rd("rimm_reg", 2'd3, '0);

    // Random phase
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        bus.instr = N'($urandom);
        step();
      end
      issue(N'($urandom));
    end
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
